stream_capture: RTL

STREAM_CAPTURE -- requirements
Module: stream_capture

---
 rtl/stream_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/stream_capture.sv
// rtl/stream_capture.sv - stream capture engine with pseudo-random backpressure and capture RAM
//
// Accepts words from a valid/ready stream (i_req/i_ack) into an internal RAM
// after a start pulse. The capture ends when EXPECT words have been accepted
// or after IDLE_LIMIT consecutive cycles without a transfer.
//
// Ports:
//   clk, reset_n         clock (rising edge), asynchronous active-low reset
//   i_dat, i_req, i_ack  stream data, valid, ready
//   start                single-cycle capture start pulse (ignored while capturing)
//   cfg_bp_en, cfg_seed  pseudo-random backpressure enable and accumulator seed
//   rd_addr, rd_data     RAM read port, one-cycle latency
//   count                number of words accepted in the current capture
//   done                 high while the capture has ended
//   timeout              capture ended on idle
//   overflow             write address wrapped during the capture
//   crc                  CRC-16-CCITT over accepted words (only with STREAM_CAPTURE_CRC_EN)
//
// Build option: define STREAM_CAPTURE_CRC_EN to add the crc output and its logic.

module stream_capture #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int EXPECT     = 1024,
    parameter int IDLE_LIMIT = 100,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_req,
    output logic             i_ack,
    input  logic             start,
    input  logic             cfg_bp_en,
    input  logic [31:0]      cfg_seed,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic [31:0]      count,
    output logic             done,
    output logic             timeout,
    output logic             overflow
`ifdef STREAM_CAPTURE_CRC_EN
    ,
    output logic [15:0]      crc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [5:0]    LFSR_INIT  = 6'b100000;
    localparam logic [31:0]   EXPECT_W   = 32'(EXPECT);
    localparam logic [7:0]    IDLE_LAST  = 8'(IDLE_LIMIT - 1);
    localparam logic [AW-1:0] WADDR_LAST = AW'(DEPTH - 1);

    state_t          state;
    logic [7:0]      idle_cnt;
    logic [AW-1:0]   waddr;
    logic [31:0]     acc;
    logic [5:0]      lfsr;

    logic [WIDTH-1:0] mem [DEPTH];

    logic            xfer;
    logic [5:0]      lfsr_next;
    logic [31:0]     acc_next;
    logic            hit_expect;
    logic            hit_idle;

    // i_ack is a register, so it is only ever high in CAPTURE; no state term needed here.
    always_comb begin
        xfer       = i_req && i_ack;
        // Galois form of x^6+x+1: bit5 feeds back into bit0 and into bit1.
        lfsr_next  = {lfsr[4:1], lfsr[0] ^ lfsr[5], lfsr[5]};
        acc_next   = acc + {26'd0, lfsr};
        hit_expect = xfer && ((count + 32'd1) == EXPECT_W);
        // The IDLE_LIMIT-th consecutive empty cycle ends the capture.
        hit_idle   = !xfer && (idle_cnt == IDLE_LAST);
    end

`ifdef STREAM_CAPTURE_CRC_EN
    // CRC-16-CCITT (poly 0x1021), data consumed MSB first, no reflection.
    function automatic logic [15:0] crc16_word(input logic [15:0] c, input logic [WIDTH-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r[15] ^ d[i]) begin
                r = {r[14:0], 1'b0} ^ 16'h1021;
            end else begin
                r = {r[14:0], 1'b0};
            end
        end
        return r;
    endfunction
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            i_ack    <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            overflow <= 1'b0;
            count    <= 32'd0;
            idle_cnt <= 8'd0;
            waddr    <= '0;
            acc      <= 32'd0;
            lfsr     <= LFSR_INIT;
`ifdef STREAM_CAPTURE_CRC_EN
            crc      <= 16'hFFFF;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state    <= S_CAPTURE;
                        done     <= 1'b0;
                        timeout  <= 1'b0;
                        overflow <= 1'b0;
                        count    <= 32'd0;
                        idle_cnt <= 8'd0;
                        waddr    <= '0;
                        acc      <= cfg_seed;
                        lfsr     <= LFSR_INIT;
                        // First CAPTURE cycle sees acc == cfg_seed.
                        i_ack    <= cfg_bp_en ? cfg_seed[0] : 1'b1;
`ifdef STREAM_CAPTURE_CRC_EN
                        crc      <= 16'hFFFF;
`endif
                    end
                end
                S_CAPTURE: begin
                    lfsr <= lfsr_next;
                    acc  <= acc_next;
                    if (xfer) begin
                        waddr    <= waddr + AW'(1);
                        count    <= count + 32'd1;
                        idle_cnt <= 8'd0;
                        if (waddr == WADDR_LAST) begin
                            overflow <= 1'b1;
                        end
`ifdef STREAM_CAPTURE_CRC_EN
                        crc <= crc16_word(crc, i_dat);
`endif
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                    // Reaching EXPECT wins over idle and leaves timeout clear.
                    if (hit_expect) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b0;
                        i_ack   <= 1'b0;
                    end else if (hit_idle) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                        i_ack   <= 1'b0;
                    end else begin
                        i_ack <= cfg_bp_en ? acc_next[0] : 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    i_ack <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    // Capture RAM: not reset; a same-address read in the write cycle returns the old word.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem[waddr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
